// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
//
// Frequency-sweep controller feeding the frequency control word of a DDS core.
// A Start pulse latches a sweep configuration. Fword then steps from the start
// word towards the stop word. Each word is held for a programmable dwell.
// The sweep runs once or repeats continuously.
//
// Ports
//   Clk         : system clock, rising edge
//   Reset_n     : asynchronous active-low reset
//   Start       : one-cycle pulse, begins a sweep from idle
//   Abort       : one-cycle pulse, ends any sweep (wins over Start / expiry)
//   Cont        : 0 = one-shot, 1 = continuous repeat (latched at Start)
//   Cfg_start   : first frequency word
//   Cfg_stop    : last frequency word
//   Cfg_step    : unsigned step magnitude
//   Cfg_dwell   : cycles each word is held, 0 behaves as 1
//   Fword       : frequency control word to the DDS
//   Busy        : high while a sweep is running
//   Sweep_done  : one-cycle pulse at each sweep completion
module dds_sweep_ctrl #(
  parameter int unsigned FW_W    = 32,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Cont,
  input  logic [FW_W-1:0]    Cfg_start,
  input  logic [FW_W-1:0]    Cfg_stop,
  input  logic [FW_W-1:0]    Cfg_step,
  input  logic [DWELL_W-1:0] Cfg_dwell,
  output logic [FW_W-1:0]    Fword,
  output logic               Busy,
  output logic               Sweep_done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [DWELL_W-1:0] DwellOne = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [FW_W-1:0]    fword_q, fword_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Latched sweep configuration
  logic [FW_W-1:0]    start_q, start_d;
  logic [FW_W-1:0]    stop_q, stop_d;
  logic [FW_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cont_q, cont_d;
  logic               up_q, up_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic               expire;
  logic               at_end;
  logic [FW_W:0]      sum_up;
  logic [FW_W:0]      diff_dn;
  logic               clamp_up;
  logic               clamp_dn;
  logic               clamp;
  logic [FW_W-1:0]    next_w;

  assign dwell_eff = (Cfg_dwell == '0) ? DwellOne : Cfg_dwell;

  // Counter holds the cycles left for the current word; the word changes on the
  // edge where the last remaining cycle is consumed.
  assign expire = (cnt_q <= DwellOne);

  assign at_end = (fword_q == stop_q) || (step_q == '0);

  // One extra bit catches carry-out (up) and borrow (down). The word is then
  // clamped to stop instead of wrapping.
  assign sum_up   = {1'b0, fword_q} + {1'b0, step_q};
  assign diff_dn  = {1'b0, fword_q} - {1'b0, step_q};
  assign clamp_up = sum_up[FW_W] || (sum_up[FW_W-1:0] >= stop_q);
  assign clamp_dn = diff_dn[FW_W] || (diff_dn[FW_W-1:0] <= stop_q);
  assign clamp    = up_q ? clamp_up : clamp_dn;
  assign next_w   = up_q ? sum_up[FW_W-1:0] : diff_dn[FW_W-1:0];

  always_comb begin
    state_d = state_q;
    fword_d = fword_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    up_d    = up_q;

    unique case (state_q)
      StIdle: begin
        if (Start && !Abort) begin
          start_d = Cfg_start;
          stop_d  = Cfg_stop;
          step_d  = Cfg_step;
          dwell_d = dwell_eff;
          cont_d  = Cont;
          up_d    = (Cfg_start <= Cfg_stop);
          fword_d = Cfg_start;
          busy_d  = 1'b1;
          cnt_d   = dwell_eff;
          state_d = StRun;
        end
      end

      StRun: begin
        if (Abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (expire) begin
          cnt_d = dwell_q;
          if (at_end) begin
            done_d = 1'b1;
            if (cont_q) begin
              fword_d = start_q;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else if (clamp) begin
            fword_d = stop_q;
          end else begin
            fword_d = next_w;
          end
        end else begin
          cnt_d = cnt_q - DwellOne;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      fword_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fword_q <= fword_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cont_q  <= cont_d;
      up_q    <= up_d;
    end
  end

  assign Fword      = fword_q;
  assign Busy       = busy_q;
  assign Sweep_done = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic        Abort;
  logic        Cont;
  logic [31:0] Cfg_start;
  logic [31:0] Cfg_stop;
  logic [31:0] Cfg_step;
  logic [23:0] Cfg_dwell;
  logic [31:0] Fword;
  logic        Busy;
  logic        Sweep_done;

  int n_tests = 0;
  int n_fail  = 0;

  dds_sweep_ctrl #(
    .FW_W    (32),
    .DWELL_W (24)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Abort      (Abort),
    .Cont       (Cont),
    .Cfg_start  (Cfg_start),
    .Cfg_stop   (Cfg_stop),
    .Cfg_step   (Cfg_step),
    .Cfg_dwell  (Cfg_dwell),
    .Fword      (Fword),
    .Busy       (Busy),
    .Sweep_done (Sweep_done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0]      s;
    logic [31:0]      p;
    logic [31:0]      st;
    logic [23:0]      dw;
    int               k;
    logic [7:0][31:0] w;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; drives Start immediately so back-to-back calls test
  // acceptance in the cycle right after Busy falls.
  task automatic run_vec(input vec_t v, input int idx);
    int d;
    d = (v.dw == 0) ? 1 : int'(v.dw);
    Cfg_start = v.s;
    Cfg_stop  = v.p;
    Cfg_step  = v.st;
    Cfg_dwell = v.dw;
    Cont      = 1'b0;
    Start     = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int c = 0; c < v.k * d; c++) begin
      check($sformatf("v%0d c%0d fword", idx, c), Fword, v.w[c / d]);
      check($sformatf("v%0d c%0d busy", idx, c), {31'd0, Busy}, 32'd1);
      check($sformatf("v%0d c%0d done", idx, c), {31'd0, Sweep_done}, 32'd0);
      @(negedge Clk);
    end
    check($sformatf("v%0d end busy", idx), {31'd0, Busy}, 32'd0);
    check($sformatf("v%0d end done", idx), {31'd0, Sweep_done}, 32'd1);
    check($sformatf("v%0d end fword", idx), Fword, v.w[v.k - 1]);
  endtask

  logic [31:0] cseq [3];

  initial begin
    vecs[0] = '{s: 32'd100, p: 32'd400, st: 32'd100, dw: 24'd3, k: 4, w: '0};
    vecs[0].w[0] = 32'd100; vecs[0].w[1] = 32'd200; vecs[0].w[2] = 32'd300;
    vecs[0].w[3] = 32'd400;
    vecs[1] = '{s: 32'd0, p: 32'd250, st: 32'd100, dw: 24'd1, k: 4, w: '0};
    vecs[1].w[0] = 32'd0; vecs[1].w[1] = 32'd100; vecs[1].w[2] = 32'd200;
    vecs[1].w[3] = 32'd250;
    vecs[2] = '{s: 32'd1000, p: 32'd700, st: 32'd150, dw: 24'd2, k: 3, w: '0};
    vecs[2].w[0] = 32'd1000; vecs[2].w[1] = 32'd850; vecs[2].w[2] = 32'd700;
    vecs[3] = '{s: 32'hFFFF_FF00, p: 32'hFFFF_FFFF, st: 32'h80, dw: 24'd1, k: 3, w: '0};
    vecs[3].w[0] = 32'hFFFF_FF00; vecs[3].w[1] = 32'hFFFF_FF80;
    vecs[3].w[2] = 32'hFFFF_FFFF;
    vecs[4] = '{s: 32'd5, p: 32'd9, st: 32'd0, dw: 24'd0, k: 1, w: '0};
    vecs[4].w[0] = 32'd5;
    vecs[5] = '{s: 32'd77, p: 32'd77, st: 32'd9, dw: 24'd2, k: 1, w: '0};
    vecs[5].w[0] = 32'd77;
    vecs[6] = '{s: 32'd100, p: 32'd0, st: 32'd60, dw: 24'd1, k: 3, w: '0};
    vecs[6].w[0] = 32'd100; vecs[6].w[1] = 32'd40; vecs[6].w[2] = 32'd0;
    cseq[0] = 32'd10; cseq[1] = 32'd20; cseq[2] = 32'd30;

    Reset_n = 1'b0; Start = 1'b0; Abort = 1'b0; Cont = 1'b0;
    Cfg_start = '0; Cfg_stop = '0; Cfg_step = '0; Cfg_dwell = '0;
    #12;
    check("rst fword", Fword, 32'd0);
    check("rst busy", {31'd0, Busy}, 32'd0);
    check("rst done", {31'd0, Sweep_done}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // One-shot table, back-to-back
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
    @(negedge Clk);
    check("idle done low", {31'd0, Sweep_done}, 32'd0);
    check("idle fword hold", Fword, 32'd0);

    // Start with Abort in idle: no start; Abort alone: no effect
    Cfg_start = 32'd555; Cfg_stop = 32'd600; Cfg_step = 32'd1; Cfg_dwell = 24'd1;
    Start = 1'b1; Abort = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start+abort busy", {31'd0, Busy}, 32'd0);
    check("start+abort fword", Fword, 32'd0);
    @(negedge Clk);
    Abort = 1'b0;
    check("idle abort busy", {31'd0, Busy}, 32'd0);

    // Continuous 10,20,30 dwell 2; Start mid-run ignored; Abort at 20
    Cfg_start = 32'd10; Cfg_stop = 32'd30; Cfg_step = 32'd10; Cfg_dwell = 24'd2;
    Cont = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Cont = 1'b0;
    Cfg_start = 32'd999; Cfg_stop = 32'd5; Cfg_step = 32'd1; Cfg_dwell = 24'd7;
    for (int c = 0; c <= 14; c++) begin
      check($sformatf("cont c%0d fword", c), Fword, cseq[(c / 2) % 3]);
      check($sformatf("cont c%0d busy", c), {31'd0, Busy}, 32'd1);
      check($sformatf("cont c%0d done", c), {31'd0, Sweep_done},
            (c > 0 && c % 6 == 0) ? 32'd1 : 32'd0);
      Start = (c == 4);
      Abort = (c == 14);
      @(negedge Clk);
    end
    Start = 1'b0; Abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("abort c%0d busy", c), {31'd0, Busy}, 32'd0);
      check($sformatf("abort c%0d fword", c), Fword, 32'd20);
      check($sformatf("abort c%0d done", c), {31'd0, Sweep_done}, 32'd0);
      @(negedge Clk);
    end

    // Abort coincident with final expiry: 1,2,3 dwell 1
    Cfg_start = 32'd1; Cfg_stop = 32'd3; Cfg_step = 32'd1; Cfg_dwell = 24'd1;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("absync pre fword", Fword, 32'd3);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("absync busy", {31'd0, Busy}, 32'd0);
    check("absync done", {31'd0, Sweep_done}, 32'd0);
    check("absync fword", Fword, 32'd3);
    @(negedge Clk);
    check("absync done2", {31'd0, Sweep_done}, 32'd0);

    // Reset mid-sweep, asynchronously between edges
    Cfg_start = 32'd100; Cfg_stop = 32'd400; Cfg_step = 32'd100; Cfg_dwell = 24'd3;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    check("pre-rst fword", Fword, 32'd200);
    #2 Reset_n = 1'b0;
    #1;
    check("async rst fword", Fword, 32'd0);
    check("async rst busy", {31'd0, Busy}, 32'd0);
    check("async rst done", {31'd0, Sweep_done}, 32'd0);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    @(negedge Clk);
    check("post-rst done", {31'd0, Sweep_done}, 32'd0);
    check("post-rst busy", {31'd0, Busy}, 32'd0);
    run_vec(vecs[0], 100);

    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller that sits directly upstream of the DDS core and drives its 32-bit frequency control word. On a start pulse it latches a sweep configuration, then steps the frequency word from a start value to a stop value in fixed increments. Each value is held for a programmable dwell time. Sweeps run once or repeat continuously. Its `Fword` output connects straight to the DDS `Fword` input. The DDS re-registers that input, so consumers see changes one clock later.

## Interface
- `FW_W`, default 32: frequency word width; must match the DDS phase accumulator.
- `DWELL_W`, default 24: dwell counter width.
- `Clk`, input, 1: single system clock; all logic is on its rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: single-cycle pulse; begins a sweep from IDLE.
- `Abort`, input, 1: single-cycle pulse; ends any sweep and returns to IDLE.
- `Cont`, input, 1: 0 = one-shot, 1 = continuous repeat; latched at Start.
- `Cfg_start`, input, FW_W: first frequency word.
- `Cfg_stop`, input, FW_W: last frequency word.
- `Cfg_step`, input, FW_W: unsigned step magnitude.
- `Cfg_dwell`, input, DWELL_W: cycles each word is held; 0 is treated as 1.
- `Fword`, output reg, FW_W: frequency control word to the DDS.
- `Busy`, output reg, 1: high while in RUN.
- `Sweep_done`, output reg, 1: one-cycle pulse at each sweep completion.

## Operation
- States:
  - IDLE: `Fword` holds its last value.
  - RUN: counting dwell / stepping.
- All `Cfg_*` and `Cont` inputs are latched on the accepted Start. Changes during RUN are ignored.
- Direction is decided at latch time: up if `Cfg_start <= Cfg_stop`, down otherwise.
- IDLE → RUN on `Start` with `Abort` low. On that edge:
  - `Fword <= Cfg_start`, `Busy <= 1`.
  - The dwell counter loads D, where D = max(`Cfg_dwell`, 1).
- In RUN the dwell counter decrements each cycle. When it expires:
  - If `Fword` equals the latched stop value, or the latched step is 0, the sweep is complete:
    - `Sweep_done` pulses.
    - One-shot: go to IDLE, `Busy <= 0`, `Fword` stays at its final value.
    - Continuous: `Fword <= start`, reload the counter, remain in RUN.
  - Otherwise:
    - Compute next = `Fword` ± step in FW_W+1 bits.
    - If next passes or equals stop (up: next ≥ stop, including carry-out; down: borrow, or next ≤ stop), then `Fword <= stop`.
    - Otherwise `Fword <= next[FW_W-1:0]`.
    - Reload the counter.
- The stop value is always emitted and held for a full dwell. `Fword` never wraps modulo 2^FW_W.
- `Abort` in RUN goes to IDLE next edge:
  - `Busy <= 0`, `Fword` holds, no `Sweep_done`.
  - `Abort` has priority over the dwell expiry in the same cycle.
- `Abort` in IDLE has no effect.
- `Start` during RUN is ignored. `Start` and `Abort` together in IDLE: no start.
- Step 0 means a single dwell at start, then completion. In continuous mode with step 0, `Fword` stays constant and `Sweep_done` pulses every D cycles.

## Timing
- Reset values: `Fword = 0`, `Busy = 0`, `Sweep_done = 0`, state IDLE, dwell counter 0, latched config 0.
- Start sampled at edge n:
  - `Fword = Cfg_start` and `Busy = 1` are visible after edge n.
  - `Fword` updates at edges n+D, n+2D, …; every value is held for exactly D cycles.
- `Sweep_done` is high for exactly one cycle, after the edge where the final stop dwell expires.
  - One-shot: `Busy` falls on the same edge.
  - Continuous: `Fword` returns to start on the same edge.
- A one-shot sweep of K distinct words lasts K·D cycles of `Busy`.
- Back-to-back: a Start in the cycle after `Busy` falls is accepted normally.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronously). No `Sweep_done` is generated.

## Test plan
- Up sweep, one-shot, start=100, stop=400, step=100, dwell=3:
  - `Fword` = 100, 200, 300, 400, each for 3 cycles.
  - `Busy` high 12 cycles; `Sweep_done` pulses once, coincident with `Busy` falling.
- Overshoot clamp, start=0, stop=250, step=100, dwell=1 → `Fword` = 0, 100, 200, 250, then done.
- Down sweep and overflow:
  - start=1000, stop=700, step=150 → 1000, 850, 700.
  - start=0xFFFF_FF00, stop=0xFFFF_FFFF, step=0x80 → 0xFFFF_FF00, 0xFFFF_FF80, 0xFFFF_FFFF; no wrap to 0.
- Continuous and abort:
  - `Cont`=1, start=10, stop=30, step=10, dwell=2 → 10, 20, 30, 10, 20, …; `Sweep_done` every 6 cycles.
  - `Abort` while `Fword`=20 → `Busy`=0 next edge, `Fword` stays 20, no `Sweep_done`.
  - `Start` pulsed mid-run has no effect.
- Degenerate configs:
  - dwell=0, step=0, start=5, one-shot → `Fword`=5 for 1 cycle, `Sweep_done` and `Busy`↓ together.
  - start==stop=77, step=9 → single dwell at 77.
  - Abort coincident with the final expiry → no `Sweep_done`.
- Reset:
  - Assert `Reset_n` low mid-sweep, between clock edges → `Fword`=0 and `Busy`=0 immediately.
  - After release, a new Start behaves as the first scenario.
